// File: rtl/dec_scan_seq_if.sv
// Control/status bundle between a scan controller and dec_scan_seq.
// The decoder-facing address/enable travel here too so the sequencer has a single bus port.
interface dec_scan_seq_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] a;
  logic       e;
  logic       busy;
  logic       line_strobe;
  logic       done;

  modport master (
    output start, stop, loop,
    input  a, e, busy, line_strobe, done
  );

  modport slave (
    input  start, stop, loop,
    output a, e, busy, line_strobe, done
  );
endinterface

// File: rtl/dec_scan_seq.sv
// Line-scan sequencer feeding the 4:16 active-low decoder.
// Each line is SETUP -> ACTIVE x DWELL -> HOLD, so the address only moves while the enable is high.
module dec_scan_seq #(
  parameter int DWELL = 4,
  parameter int LAST  = 15
) (
  input logic           clk,
  input logic           rst_n,
  dec_scan_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] DWELL_END = 8'(DWELL - 1);
  localparam logic [3:0] LAST_LINE = 4'(LAST);

  state_t     state, next_state;
  logic [3:0] line, next_line;
  logic [7:0] cnt, next_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      line  <= 4'd0;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      line  <= next_line;
      cnt   <= next_cnt;
    end
  end

  // The line index is parked at 0 whenever the sequencer is not scanning,
  // so it doubles directly as the decoder address.
  always_comb begin
    next_state = state;
    next_line  = line;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        next_line = 4'd0;
        next_cnt  = 8'd0;
        if (bus.start && !bus.stop) next_state = SETUP;
      end
      SETUP: begin
        next_state = ACTIVE;
        next_cnt   = 8'd0;
      end
      ACTIVE: begin
        next_cnt = cnt + 8'd1;
        if (cnt == DWELL_END) next_state = HOLD;
      end
      HOLD: begin
        if (line != LAST_LINE) begin
          next_state = SETUP;
          next_line  = line + 4'd1;
        end else if (bus.loop) begin
          next_state = SETUP;
          next_line  = 4'd0;
        end else begin
          next_state = DONE;
          next_line  = 4'd0;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_line  = 4'd0;
      end
      default: begin
        next_state = IDLE;
        next_line  = 4'd0;
        next_cnt   = 8'd0;
      end
    endcase

    // Abort overrides every scanning transition, including a pending DONE.
    if ((state == SETUP || state == ACTIVE || state == HOLD) && bus.stop) begin
      next_state = IDLE;
      next_line  = 4'd0;
      next_cnt   = 8'd0;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a           <= 4'd0;
      bus.e           <= 1'b1;
      bus.busy        <= 1'b0;
      bus.line_strobe <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.a           <= next_line;
      bus.e           <= (next_state != ACTIVE);
      bus.busy        <= (next_state == SETUP) || (next_state == ACTIVE) || (next_state == HOLD);
      bus.line_strobe <= (next_state == HOLD);
      bus.done        <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Randomized scoreboard bench for dec_scan_seq: default build plus a DWELL=1/LAST=3 build.
// Expected per-cycle outputs come from a frame/line/phase arithmetic model, not from the FSM.
module tb_dec_scan_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_scan_seq_if bus0 ();
  dec_scan_seq_if bus1 ();

  dec_scan_seq #(.DWELL(4), .LAST(15)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dec_scan_seq #(.DWELL(1), .LAST(3))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic       e;
    logic       busy;
    logic       strobe;
    logic       done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] pa[2] = '{4'd0, 4'd0};
  logic       pe[2] = '{1'b1, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  // k counts cycles after the IDLE cycle in which start was sampled.
  function automatic exp_t model(int k, int dw, int last, int nf, int abort_k);
    exp_t r;
    int   f, rr, ph;
    f = (last + 1) * (dw + 2);
    r.cyc = 0; r.a = 4'd0; r.e = 1'b1; r.busy = 1'b0; r.strobe = 1'b0; r.done = 1'b0;
    if (abort_k > 0 && k > abort_k) return r;
    if (k >= 1 && k <= nf * f) begin
      rr       = (k - 1) % f;
      ph       = rr % (dw + 2);
      r.a      = 4'(rr / (dw + 2));
      r.busy   = 1'b1;
      r.e      = !(ph >= 1 && ph <= dw);
      r.strobe = (ph == dw + 1);
    end else if (k == nf * f + 1) begin
      r.done = 1'b1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input exp_t x, input logic [3:0] a, input logic e,
                             input logic busy, input logic strobe, input logic done);
    vectors++;
    if ({a, e, busy, strobe, done} !== {x.a, x.e, x.busy, x.strobe, x.done}) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got a=%0d e=%b busy=%b strobe=%b done=%b, expected a=%0d e=%b busy=%b strobe=%b done=%b",
               name, cyc, a, e, busy, strobe, done, x.a, x.e, x.busy, x.strobe, x.done);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic s, input logic p, input logic l);
    if (sel == 0) begin
      bus0.start = s; bus0.stop = p; bus0.loop = l;
    end else begin
      bus1.start = s; bus1.stop = p; bus1.loop = l;
    end
  endtask

  function automatic void pushExp(input int sel, input exp_t r);
    if (sel == 0) q0.push_back(r);
    else          q1.push_back(r);
  endfunction

  task automatic monitorStep(input int sel);
    exp_t       r;
    logic [3:0] a;
    logic       e, b, s, d;
    if (sel == 0) {a, e, b, s, d} = {bus0.a, bus0.e, bus0.busy, bus0.line_strobe, bus0.done};
    else          {a, e, b, s, d} = {bus1.a, bus1.e, bus1.busy, bus1.line_strobe, bus1.done};
    if (rst_n) begin
      forever begin
        if (sel == 0) begin
          if (q0.size() == 0 || q0[0].cyc > cyc) break;
          r = q0.pop_front();
        end else begin
          if (q1.size() == 0 || q1[0].cyc > cyc) break;
          r = q1.pop_front();
        end
        checkOutput($sformatf("dut%0d_trace", sel), r, a, e, b, s, d);
      end
      // The address must be stable across every cycle in which the decoder is enabled.
      if (e == 1'b0) begin
        vectors++;
        if (a !== pa[sel]) begin
          miscompares++;
          $display("[TB] FAIL dut%0d_a_moved_while_enabled cyc=%0d got a=%0d, expected a=%0d",
                   sel, cyc, a, pa[sel]);
        end
      end
    end
    pa[sel] = a;
    pe[sel] = e;
  endtask

  always @(negedge clk) begin
    monitorStep(0);
    monitorStep(1);
  end

  task automatic runFrame(input int sel, input int dw, input int last, input int nf,
                          input int abort_k, input int lead, input bit noise);
    exp_t r;
    int   f, p, busy_end, stop_k;
    logic both, s, l;
    f        = (last + 1) * (dw + 2);
    busy_end = (abort_k > 0) ? abort_k : nf * f + 1;
    stop_k   = busy_end + 3;
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      both = noise ? 1'($urandom % 2) : 1'b0;
      applyStimulus(sel, both, both, 1'($urandom % 2));
      r = model(0, dw, last, nf, 0);
      r.cyc = cyc + 1;
      pushExp(sel, r);
    end
    @(negedge clk);
    p = cyc;
    applyStimulus(sel, 1'b1, 1'b0, 1'($urandom % 2));
    for (int k = 1; k <= stop_k; k++) begin
      r = model(k, dw, last, nf, abort_k);
      r.cyc = p + k;
      pushExp(sel, r);
    end
    for (int k = 1; k < stop_k; k++) begin
      @(negedge clk);
      s = (noise && k <= busy_end) ? 1'($urandom % 2) : 1'b0;
      l = 1'($urandom % 2);
      if (k <= nf * f && (k - 1) % f == f - 1) l = ((k - 1) / f < nf - 1);
      if (k > busy_end) l = 1'b0;
      applyStimulus(sel, s, (k == abort_k), l);
    end
  endtask

  task automatic resetScenario();
    exp_t r, idle;
    int   p;
    idle = model(0, 4, 15, 1, 0);
    @(negedge clk);
    p = cyc;
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      r = model(k, 4, 15, 1, 0);
      r.cyc = p + k;
      pushExp(0, r);
    end
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_mid_line7", idle, bus0.a, bus0.e, bus0.busy, bus0.line_strobe, bus0.done);
    @(posedge clk);
    #1 checkOutput("reset_held", idle, bus0.a, bus0.e, bus0.busy, bus0.line_strobe, bus0.done);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = idle;
      r.cyc = cyc + 1;
      pushExp(0, r);
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t idle;
    int   nf, ab;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    idle = model(0, 4, 15, 1, 0);
    #12;
    checkOutput("reset_dut0", idle, bus0.a, bus0.e, bus0.busy, bus0.line_strobe, bus0.done);
    checkOutput("reset_dut1", idle, bus1.a, bus1.e, bus1.busy, bus1.line_strobe, bus1.done);
    @(negedge clk);
    rst_n = 1'b1;

    runFrame(0, 4, 15, 1, 0, 2, 1'b0);
    runFrame(0, 4, 15, 2, 0, 1, 1'b1);
    runFrame(0, 4, 15, 4, 120, 1, 1'b1);
    runFrame(0, 4, 15, 1, 33, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nf = $urandom_range(2, 1);
      ab = ($urandom % 2 == 0) ? 0 : $urandom_range(nf * 96, 1);
      runFrame(0, 4, 15, nf, ab, $urandom_range(3, 1), 1'b1);
    end
    resetScenario();

    runFrame(1, 1, 3, 1, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      nf = $urandom_range(3, 1);
      ab = ($urandom % 2 == 0) ? 0 : $urandom_range(nf * 12, 1);
      runFrame(1, 1, 3, nf, ab, $urandom_range(3, 1), 1'b1);
    end

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain got %0d/%0d pending entries, expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
